// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state type and default sizing for the load-use hazard scoreboard.
package hazard_pkg;
    localparam int REG_AW_DEF   = 5;
    localparam int NUM_SRC_DEF  = 2;
    localparam int LOAD_LAT_DEF = 1;

    typedef enum logic {
        IDLE,
        STALL
    } hz_state_e;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID/EX operand info in, pipeline stall/freeze control out.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_SRC = NUM_SRC_DEF
);
    logic [NUM_SRC*REG_AW-1:0] id_rs_i;
    logic [NUM_SRC-1:0]        id_rs_used_i;
    logic [REG_AW-1:0]         ex_rd_i;
    logic                      ex_mem_read_i;
    logic                      flush_i;
    logic                      mem_busy_i;
    logic                      pc_write_o;
    logic                      if_id_stall_o;
    logic                      id_ex_noop_o;
    logic                      freeze_o;

    modport slave (
        input  id_rs_i, id_rs_used_i, ex_rd_i, ex_mem_read_i, flush_i, mem_busy_i,
        output pc_write_o, if_id_stall_o, id_ex_noop_o, freeze_o
    );

    modport master (
        output id_rs_i, id_rs_used_i, ex_rd_i, ex_mem_read_i, flush_i, mem_busy_i,
        input  pc_write_o, if_id_stall_o, id_ex_noop_o, freeze_o
    );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: one ID source operand compared against the EX destination.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              used,
    input  logic [REG_AW-1:0] rd,
    output logic              hit
);
    assign hit = used && (rs == rd);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use stall FSM holding IF/ID and bubbling ID/EX for LOAD_LAT cycles.
// Optional HAZARD_STATS_EN adds a saturating 32-bit count of inserted bubbles (stall_cnt_o).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int NUM_SRC  = NUM_SRC_DEF,
    parameter int LOAD_LAT = LOAD_LAT_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hazard_scoreboard_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);
    localparam int              CW     = $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0]   LAT_M1 = CW'(LOAD_LAT - 1);
    localparam bit              MULTI  = LOAD_LAT > 1;

    hz_state_e          r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [REG_AW-1:0]  r_pend, w_pend_nxt;
    logic [NUM_SRC-1:0] w_src_hit;
    logic               w_hit, w_stall, w_freeze, w_if_id, w_noop;

    genvar k;
    for (k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_match #(.REG_AW(REG_AW)) u_match (
            .rs   (bus.id_rs_i[k*REG_AW +: REG_AW]),
            .used (bus.id_rs_used_i[k]),
            .rd   (bus.ex_rd_i),
            .hit  (w_src_hit[k])
        );
    end

    // r0 is hardwired zero, so a load targeting it can never create a dependency
    assign w_hit = bus.ex_mem_read_i && (bus.ex_rd_i != '0) && (|w_src_hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        if (bus.flush_i) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (!bus.mem_busy_i) begin
            if (r_state == IDLE) begin
                if (w_hit && MULTI) begin
                    w_state_nxt = STALL;
                    w_cnt_nxt   = LAT_M1;
                    w_pend_nxt  = bus.ex_rd_i;
                end
            end else begin
                w_cnt_nxt   = r_cnt - CW'(1);
                w_state_nxt = (r_cnt == CW'(1)) ? IDLE : STALL;
            end
        end
    end

    always_comb begin
        w_stall  = !bus.flush_i && ((r_state == STALL) || w_hit);
        w_freeze = bus.mem_busy_i;
        w_if_id  = w_stall || w_freeze;
        w_noop   = w_stall && !w_freeze;
    end

    assign bus.freeze_o      = w_freeze;
    assign bus.if_id_stall_o = w_if_id;
    assign bus.pc_write_o    = !w_if_id;
    assign bus.id_ex_noop_o  = w_noop;

    // STALL is only entered from a hit, which requires a nonzero destination
    a_pend_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == STALL) |-> (r_pend != '0));

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_stall_cnt <= '0;
        else if (w_noop && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors driven into LOAD_LAT=1 and LOAD_LAT=3 instances side by side.
module tb_hazard_scoreboard;
    localparam logic [3:0] IDL = 4'b1000;
    localparam logic [3:0] STL = 4'b0110;
    localparam logic [3:0] FRZ = 4'b0101;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(5), .NUM_SRC(2)) bus1 ();
    hazard_scoreboard_if #(.REG_AW(5), .NUM_SRC(2)) bus3 ();

`ifdef HAZARD_STATS_EN
    logic [31:0] cnt1, cnt3;
`endif

    hazard_scoreboard #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1)) u_l1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt_o (cnt1)
`endif
    );

    hazard_scoreboard #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3)) u_l3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt_o (cnt3)
`endif
    );

    wire logic [3:0] o1 = {bus1.pc_write_o, bus1.if_id_stall_o, bus1.id_ex_noop_o, bus1.freeze_o};
    wire logic [3:0] o3 = {bus3.pc_write_o, bus3.if_id_stall_o, bus3.id_ex_noop_o, bus3.freeze_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] used,
                         input logic [4:0] rd, input logic mr, input logic fl, input logic mb);
        bus1.id_rs_i = {s1, s0};  bus3.id_rs_i = {s1, s0};
        bus1.id_rs_used_i = used; bus3.id_rs_used_i = used;
        bus1.ex_rd_i = rd;        bus3.ex_rd_i = rd;
        bus1.ex_mem_read_i = mr;  bus3.ex_mem_read_i = mr;
        bus1.flush_i = fl;        bus3.flush_i = fl;
        bus1.mem_busy_i = mb;     bus3.mem_busy_i = mb;
    endtask

    // one clock: new inputs shortly after the edge, outputs sampled mid-cycle
    task automatic cyc(input string tag, input logic [4:0] s1, input logic [4:0] s0,
                       input logic [1:0] used, input logic [4:0] rd, input logic mr,
                       input logic fl, input logic mb, input logic [3:0] e1, input logic [3:0] e3);
        @(posedge clk);
        #2;
        drive(s1, s0, used, rd, mr, fl, mb);
        #1;
        check({tag, "_l1"}, {28'd0, o1}, {28'd0, e1});
        check({tag, "_l3"}, {28'd0, o3}, {28'd0, e3});
    endtask

    initial begin
        drive(0, 0, 2'b00, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        check("reset_l1", {28'd0, o1}, {28'd0, IDL});
        check("reset_l3", {28'd0, o3}, {28'd0, IDL});
        @(posedge clk);
        #2 rst = 1'b0;

        cyc("lat1_hit",  0, 5, 2'b01, 5, 1, 0, 0, STL, STL);
        cyc("lat1_c2",   0, 0, 2'b00, 0, 0, 0, 0, IDL, STL);
        cyc("lat1_c3",   0, 0, 2'b00, 0, 0, 0, 0, IDL, STL);
        cyc("lat1_c4",   0, 0, 2'b00, 0, 0, 0, 0, IDL, IDL);

        cyc("lat3_hit",  7, 0, 2'b10, 7, 1, 0, 0, STL, STL);
        cyc("lat3_c2",   0, 0, 2'b00, 0, 0, 0, 0, IDL, STL);
        cyc("lat3_c3",   0, 0, 2'b00, 0, 0, 0, 0, IDL, STL);
        cyc("lat3_end",  0, 0, 2'b00, 0, 0, 0, 0, IDL, IDL);

        cyc("rd_zero",   0, 0, 2'b01, 0, 1, 0, 0, IDL, IDL);
        cyc("unused",    0, 9, 2'b00, 9, 1, 0, 0, IDL, IDL);
        cyc("not_load",  0, 9, 2'b01, 9, 0, 0, 0, IDL, IDL);
        cyc("mismatch",  3, 9, 2'b11, 4, 1, 0, 0, IDL, IDL);

        cyc("frz_hit",   0, 7, 2'b01, 7, 1, 0, 0, STL, STL);
        cyc("frz_b1",    0, 0, 2'b00, 0, 0, 0, 1, FRZ, FRZ);
        cyc("frz_b2",    0, 0, 2'b00, 0, 0, 0, 1, FRZ, FRZ);
        cyc("frz_res1",  0, 0, 2'b00, 0, 0, 0, 0, IDL, STL);
        cyc("frz_res2",  0, 0, 2'b00, 0, 0, 0, 0, IDL, STL);
        cyc("frz_end",   0, 0, 2'b00, 0, 0, 0, 0, IDL, IDL);

        cyc("fl_hit",    0, 5, 2'b01, 5, 1, 1, 0, IDL, IDL);
        cyc("fl_after",  0, 0, 2'b00, 0, 0, 0, 0, IDL, IDL);
        cyc("fl2_hit",   0, 5, 2'b01, 5, 1, 0, 0, STL, STL);
        cyc("fl2_stall", 0, 0, 2'b00, 0, 0, 1, 0, IDL, IDL);
        cyc("fl2_idle",  0, 0, 2'b00, 0, 0, 0, 0, IDL, IDL);

        cyc("rs_hit",    0, 6, 2'b01, 6, 1, 0, 0, STL, STL);
        cyc("rs_mid",    0, 0, 2'b00, 0, 0, 0, 0, IDL, STL);
`ifdef HAZARD_STATS_EN
        check("cnt1_pre", cnt1, 32'd5);
        check("cnt3_pre", cnt3, 32'd11);
`endif
        rst = 1'b1;
        #1;
        check("rst_mid_l1", {28'd0, o1}, {28'd0, IDL});
        check("rst_mid_l3", {28'd0, o3}, {28'd0, IDL});
`ifdef HAZARD_STATS_EN
        check("cnt1_rst", cnt1, 32'd0);
        check("cnt3_rst", cnt3, 32'd0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;
        cyc("post_rst",  0, 0, 2'b00, 0, 0, 0, 0, IDL, IDL);
        cyc("post_hit",  7, 0, 2'b10, 7, 1, 0, 0, STL, STL);
        cyc("post_c2",   0, 0, 2'b00, 0, 0, 0, 0, IDL, STL);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of ID-stage source operands checked (1..4).
REQ-003 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles required (1..7).
REQ-004 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port id_rs_i  in  NUM_SRC*REG_AW  ID source addresses, source k at bits [k*REG_AW +: REG_AW].
REQ-007 SHALL have port id_rs_used_i  in  NUM_SRC  per-source "operand actually read" qualifier.
REQ-008 SHALL have port ex_rd_i  in  REG_AW  EX-stage destination address.
REQ-009 SHALL have port ex_mem_read_i  in  1  EX-stage instruction is a load.
REQ-010 SHALL have port flush_i  in  1  ID instruction squashed this cycle (taken branch).
REQ-011 SHALL have port mem_busy_i  in  1  data memory not ready; whole pipe must freeze.
REQ-012 SHALL have port pc_write_o  out  1  PC update enable.
REQ-013 SHALL have port if_id_stall_o  out  1  hold IF/ID register.
REQ-014 SHALL have port id_ex_noop_o  out  1  insert bubble into ID/EX.
REQ-015 SHALL have port freeze_o  out  1  hold all pipeline registers.

Function
REQ-016 SHALL detect hit when ex_mem_read_i=1, ex_rd_i!=0, and some source k has id_rs_used_i[k]=1 with id_rs_k==ex_rd_i; address 0 never hits.
REQ-017 SHALL implement FSM states IDLE and STALL, with a pending-rd register and a down-counter of width clog2(LOAD_LAT+1).
REQ-018 In IDLE, hit SHALL assert stall combinationally in the same cycle; if LOAD_LAT>1, SHALL move to STALL, latch ex_rd_i, and load the counter with LOAD_LAT-1.
REQ-019 In STALL, stall SHALL be asserted and the counter SHALL decrement each un-frozen cycle; at counter==1 with no freeze, SHALL return to IDLE next edge.
REQ-020 Total stall SHALL be exactly LOAD_LAT un-frozen cycles per hit; LOAD_LAT=1 SHALL never enter STALL.
REQ-021 flush_i=1 SHALL force stall=0 that cycle and return FSM to IDLE next edge; flush SHALL win over a simultaneous hit.
REQ-022 mem_busy_i=1 SHALL freeze the FSM, counter and pending-rd, and SHALL assert freeze_o.
REQ-023 Outputs: if_id_stall_o=stall|freeze_o; pc_write_o=!if_id_stall_o; id_ex_noop_o=stall&!freeze_o.

Reset
REQ-024 rst_i=1 SHALL immediately set FSM=IDLE, counter=0, pending-rd=0, stall_cnt_o=0.
REQ-025 Reset mid-STALL SHALL abort the stall; with quiescent inputs, outputs SHALL be pc_write_o=1, if_id_stall_o=0, id_ex_noop_o=0, freeze_o=0.

Configuration
REQ-026 With HAZARD_STATS_EN defined, SHALL add port stall_cnt_o  out  32 , incrementing on every cycle id_ex_noop_o=1 and saturating at all-ones.
REQ-027 Without HAZARD_STATS_EN, port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package hazard_pkg SHALL hold the FSM state enum and the default REG_AW, NUM_SRC and LOAD_LAT constants.
REQ-029 Per-source compare SHALL be a sub-module hazard_match (inputs rs, used, rd; output hit), instantiated NUM_SRC times.

Verification
REQ-030 LOAD_LAT=1, load rd=5, id rs1=5 used -> stall and noop for 1 cycle, pc_write_o=0 that cycle only.
REQ-031 LOAD_LAT=3, load rd=7, rs2=7 used -> noop for exactly 3 consecutive cycles, then pc_write_o=1.
REQ-032 Load rd=0 with rs1=0, or rs1=9 match with id_rs_used_i[0]=0 -> no stall.
REQ-033 LOAD_LAT=3 hit, mem_busy_i=1 for 2 cycles in stall cycle 2 -> freeze_o=1 and noop=0 for 2 cycles; stall resumes; total noop count is 3.
REQ-034 Hit with flush_i=1 same cycle -> no stall; flush in STALL cycle 2 -> stall drops that cycle; FSM returns to IDLE.
REQ-035 rst_i pulsed mid-STALL -> outputs return to idle values asynchronously; with HAZARD_STATS_EN, stall_cnt_o reads 0.
